// File: rtl/angle_convert_scheduler.sv
// Round-robin scheduler sharing one Q1.14 radian-to-degree multiplier between N_CH
// attitude channels; holds the latest degree result per channel with a completion pulse.
module angle_convert_scheduler #(
  parameter int                 N_CH      = 3,
  parameter logic signed [31:0] SCALE_Q14 = 32'sd938735,
  parameter int                 SHIFT     = 28
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic [N_CH-1:0]      req_valid,
  input  logic [16*N_CH-1:0]   req_rad,
  output logic [N_CH-1:0]      req_ready,
  output logic [16*N_CH-1:0]   deg_out,
  output logic [N_CH-1:0]      deg_valid,
  output logic                 busy
);

  localparam int IDXW = (N_CH > 1) ? $clog2(N_CH) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_MULT  = 2'd1,
    S_WRITE = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [IDXW-1:0]     r_rr_ptr;
  logic [IDXW-1:0]     r_ch;
  logic [IDXW-1:0]     w_sel;
  logic                w_hit;
  logic                w_grant;
  logic signed [15:0]  r_operand;
  logic signed [63:0]  r_product;
  logic signed [63:0]  w_op64;
  logic signed [63:0]  w_scale64;
  logic signed [15:0]  w_deg;
  logic [16*N_CH-1:0]  r_deg;
  logic [N_CH-1:0]     r_deg_valid;

  // Scan downward in priority so the last hit is the nearest valid channel after rr_ptr.
  always_comb begin
    w_sel = '0;
    w_hit = 1'b0;
    for (int k = N_CH; k >= 1; k--) begin
      int idx;
      idx   = (int'(r_rr_ptr) + k) % N_CH;
      w_sel = req_valid[idx] ? IDXW'(idx) : w_sel;
      w_hit = w_hit | req_valid[idx];
    end
    w_grant = w_hit && enable && (r_state == S_IDLE) && !rst;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  w_state_nxt = w_grant ? S_MULT : S_IDLE;
      S_MULT:  w_state_nxt = S_WRITE;
      S_WRITE: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_op64    = 64'(r_operand);
  assign w_scale64 = 64'(SCALE_Q14);
  assign w_deg     = 16'(r_product >>> SHIFT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_rr_ptr  <= IDXW'(N_CH - 1);
      r_ch      <= '0;
      r_operand <= 16'sd0;
      r_product <= 64'sd0;
    end else begin
      r_state <= w_state_nxt;
      if (w_grant) begin
        r_rr_ptr  <= w_sel;
        r_ch      <= w_sel;
        r_operand <= req_rad[16*w_sel +: 16];
      end
      if (r_state == S_MULT) begin
        r_product <= w_op64 * w_scale64;
      end
    end
  end

  // Only the channel being written changes; the others keep their last result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_deg       <= '0;
      r_deg_valid <= '0;
    end else begin
      r_deg_valid <= '0;
      if (r_state == S_WRITE) begin
        r_deg[16*r_ch +: 16] <= w_deg;
        r_deg_valid          <= {{(N_CH-1){1'b0}}, 1'b1} << r_ch;
      end
    end
  end

  assign req_ready = w_grant ? ({{(N_CH-1){1'b0}}, 1'b1} << w_sel) : '0;
  assign deg_out   = r_deg;
  assign deg_valid = r_deg_valid;
  assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_angle_convert_scheduler.sv
// Scoreboard bench for angle_convert_scheduler: queued requesters, cycle model of the
// arbiter/FSM timing, and expected degree results checked on each completion pulse.
module tb_angle_convert_scheduler;
  localparam int N = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              enable = 1'b0;
  logic [N-1:0]      req_valid = '0;
  logic [16*N-1:0]   req_rad = '0;
  logic [N-1:0]      req_ready;
  logic [16*N-1:0]   deg_out;
  logic [N-1:0]      deg_valid;
  logic              busy;

  always #5 clk = ~clk;

  angle_convert_scheduler #(.N_CH(N)) u_dut (
    .clk(clk), .rst(rst), .enable(enable),
    .req_valid(req_valid), .req_rad(req_rad), .req_ready(req_ready),
    .deg_out(deg_out), .deg_valid(deg_valid), .busy(busy)
  );

  typedef struct {int ch; int val; int due;} sb_t;
  sb_t sb[$];
  int  q_rad[N][$];
  int  q_exp[N][$];
  int  checks = 0, errors = 0, cyc = 0;
  int  m_phase = 0, m_rr = N - 1, m_sel = 0;
  bit  m_grant;
  logic signed [15:0] m_deg[N];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [16*N-1:0] pack_deg();
    logic [16*N-1:0] v;
    v = '0;
    for (int i = 0; i < N; i++) v[16*i +: 16] = m_deg[i];
    return v;
  endfunction

  // floor(rad * 180/pi in Q14 / 2^28) via an arithmetic shift of the wide product
  function automatic int model_deg(input int rad);
    longint p;
    p = longint'(rad) * longint'(938735);
    return int'(p >>> 28);
  endfunction

  task automatic push_req(input int ch, input int rad, input int exp);
    q_rad[ch].push_back(rad);
    q_exp[ch].push_back(exp);
  endtask

  task automatic push_rand(input int ch, input int rad);
    push_req(ch, rad, model_deg(rad));
  endtask

  task automatic present();
    for (int ch = 0; ch < N; ch++) begin
      if (!req_valid[ch] && q_rad[ch].size() > 0) begin
        req_rad[16*ch +: 16] = 16'(q_rad[ch][0]);
        req_valid[ch] = 1'b1;
      end
    end
  endtask

  function automatic bit pending();
    bit p;
    p = |req_valid;
    for (int ch = 0; ch < N; ch++) p = p | (q_rad[ch].size() > 0);
    return p;
  endfunction

  task automatic cycle();
    logic [N-1:0] exp_ready;
    sb_t e;
    @(negedge clk);
    cyc++;
    m_grant = 1'b0;
    if (m_phase == 0 && enable) begin
      for (int k = 1; k <= N; k++) begin
        int idx;
        idx = (m_rr + k) % N;
        if (!m_grant && req_valid[idx]) begin
          m_grant = 1'b1;
          m_sel = idx;
        end
      end
    end
    exp_ready = m_grant ? (N'(1) << m_sel) : '0;
    check("ready", req_ready, exp_ready);
    check("busy", busy, m_phase != 0);
    if (deg_valid != '0) begin
      if (sb.size() == 0) begin
        check("spurious_valid", deg_valid, 0);
      end else begin
        e = sb.pop_front();
        check("valid_ch", deg_valid, N'(1) << e.ch);
        check("latency", cyc, e.due);
        m_deg[e.ch] = 16'(e.val);
        check("deg_vec", deg_out, pack_deg());
      end
    end else if (sb.size() > 0 && sb[0].due <= cyc) begin
      check("missing_valid", deg_valid, N'(1) << sb[0].ch);
      void'(sb.pop_front());
    end
    @(posedge clk);
    #1;
    if (m_grant) begin
      sb.push_back('{ch: m_sel, val: q_exp[m_sel][0], due: cyc + 3});
      void'(q_rad[m_sel].pop_front());
      void'(q_exp[m_sel].pop_front());
      req_valid[m_sel] = 1'b0;
      m_rr = m_sel;
      m_phase = 1;
    end else if (m_phase == 1) begin
      m_phase = 2;
    end else if (m_phase == 2) begin
      m_phase = 0;
    end
    present();
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    #1;
    check("rst_deg", deg_out, 0);
    check("rst_valid", deg_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", req_ready, 0);
    sb.delete();
    m_phase = 0;
    m_rr = N - 1;
    for (int i = 0; i < N; i++) m_deg[i] = 16'sd0;
    @(posedge clk);
    @(posedge clk);
    #1;
    present();
    rst = 1'b0;
  endtask

  task automatic drain(input int maxc);
    int n;
    n = 0;
    while (pending() || m_phase != 0 || sb.size() > 0) begin
      if (n >= maxc) begin
        check("drain_timeout", 1, 0);
        break;
      end
      cycle();
      n++;
    end
  endtask

  task automatic run_until_mult(input int maxc);
    int n;
    n = 0;
    do begin
      cycle();
      n++;
    end while (m_phase != 1 && n < maxc);
    if (m_phase != 1) check("mult_timeout", 1, 0);
  endtask

  initial begin
    #2;
    apply_reset();
    enable = 1'b1;

    push_req(0, 16384, 57);
    drain(50);
    push_req(1, -16384, -58);
    push_req(2, 25736, 90);
    push_req(0, 0, 0);
    drain(50);
    push_req(1, -32768, -115);
    drain(50);
    push_req(2, 32767, 114);
    drain(50);

    // all channels valid from reset release: grants 0,1,2,0,1 back to back
    push_rand(0, 5000);
    push_rand(0, -12000);
    push_rand(1, 7000);
    push_rand(1, 20000);
    push_rand(2, -3000);
    apply_reset();
    drain(50);

    // reset lands in MULT: that result is dropped and arbitration restarts at ch0
    push_rand(1, 9000);
    push_rand(2, 8000);
    run_until_mult(20);
    push_rand(0, -7000);
    apply_reset();
    drain(50);

    enable = 1'b0;
    push_rand(0, 1234);
    push_rand(1, -4321);
    repeat (5) cycle();
    enable = 1'b1;
    run_until_mult(20);
    enable = 1'b0;
    repeat (6) cycle();
    enable = 1'b1;
    drain(50);

    repeat (20) push_rand(int'($urandom_range(0, N - 1)), int'($urandom_range(0, 65535)) - 32768);
    drain(300);
    check("sb_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/angle_convert_scheduler.md
Name: angle_convert_scheduler

Overview:
- Time-shares one radian-to-degree multiplier (Q1.14 radians × 938735, arithmetic shift right 28) between N_CH attitude channels (roll, pitch, yaw by default).
- Requesters present samples over valid/ready; the block grants round-robin, runs the conversion through a 3-state FSM, and holds the latest degree result per channel with a one-cycle completion pulse.
- Sits between the attitude estimator outputs and the stabilization/telemetry logic.

Parameters:
- N_CH, 3, number of requesting channels (2..8).
- SCALE_Q14, 938735, 180/π in Q14 (signed 32-bit).
- SHIFT, 28, right-shift applied to the 64-bit product.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  when low, no new grants; an in-flight conversion completes.
- req_valid  in  N_CH  per-channel request valid.
- req_rad  in  16*N_CH  per-channel signed Q1.14 radians; channel i at bits [16i+15:16i].
- req_ready  out  N_CH  per-channel accept; one-hot or zero.
- deg_out  out  16*N_CH  per-channel signed integer degrees, held until overwritten.
- deg_valid  out  N_CH  one-cycle pulse on the channel whose deg_out just updated.
- busy  out  1  high while in MULT or WRITE.

Behaviour:
- Reset (async assert, sync release): state=IDLE, rr_ptr=N_CH-1, all deg_out=0, deg_valid=0, busy=0, operand/product registers=0. Reset mid-conversion discards it; no deg_valid is produced for it.
- States: IDLE, MULT, WRITE.
- IDLE:
  - If enable=1 and any req_valid, select the first valid channel searching upward from rr_ptr+1, wrapping modulo N_CH.
  - req_ready[sel] is asserted combinationally in this cycle; all other ready bits are 0.
  - On that edge: latch operand and channel index, set rr_ptr=sel, go to MULT.
  - If enable=0 or no valid, req_ready=0 and the FSM stays in IDLE.
- MULT: product = sign-extend(operand) to 32 bits × SCALE_Q14, registered as signed 64-bit. Go to WRITE.
- WRITE:
  - deg_out[ch] <= product >>> SHIFT, taking the low 16 bits.
  - deg_valid[ch]=1 for exactly this cycle's registered output, i.e. visible in the cycle after WRITE. Go to IDLE.
- req_ready is 0 in MULT and WRITE.
- Latency: acceptance edge to deg_valid high = 3 clocks. Maximum throughput = one conversion per 3 clocks.
- Arithmetic: the shift is arithmetic, so the result is floor(rad × 938735 / 2^28), rounding toward −∞. The full Q1.14 range (−2..+2 rad → −115..+114) always fits in 16 bits; no saturation is needed.
- Fairness: a channel holding valid continuously waits at most N_CH−1 other grants.
- Requester rule: a requester keeps req_valid and req_rad stable until it sees ready; the block samples req_rad only on the accept edge.
- enable falling in MULT or WRITE: the current conversion still completes and pulses; no further grant follows.
- Untouched channels' deg_out values are never modified.
- busy = (state != IDLE).

Test Plan:
- Reset, then ch0 valid with req_rad=16384 (1.0 rad) → ready[0] high in the same cycle; deg_out[0]=57 and deg_valid=3'b001 for one cycle, 3 clocks after accept.
- ch1 req_rad=−16384 → deg_out[1]=−58 (floor). ch2 req_rad=25736 (π/2) → deg_out[2]=90. req_rad=0 → 0.
- All three valid continuously from reset → grant order 0,1,2,0,1 with accepts spaced 3 clocks apart; busy low only in the grant cycles.
- Extremes: req_rad=−32768 → −115; req_rad=32767 → 114. Other channels' deg_out unchanged.
- Assert rst during MULT → all outputs 0 immediately; no deg_valid after release; next grant goes to ch0.
- enable=0 with requests pending → no ready. Drop enable during MULT → that result still pulses; no new grant until enable returns.
